ram_bist_scheduler: RTL and testbench
=====================================

# ram_bist_scheduler

- Sits between the system's functional RAM port, the ASTRA transparent BIST engine and the 4×3-bit RAM; owns the RAM pins at all times.
- Serves user read/write requests with a req/ack handshake.
- Periodically, or on demand, launches an ASTRA march and hands the RAM pins to the BIST engine for the march's duration.
- Collects pass/fail results into saturating counters and a sticky fault flag.

## Interface
- `TEST_PERIOD`, 64: idle cycles between automatic tests (≥2).
- `MARCH_TIMEOUT`, 64: max cycles in TESTING before declaring failure.
- `START_WAIT`, 4: max cycles waiting for `bist_marching` to rise.
- `in_clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `usr_req` in 1: access request; held until `usr_ack`.
- `usr_we` in 1: 1 = write, 0 = read.
- `usr_addr` in 2: RAM address.
- `usr_wdata` in 3: write data.
- `usr_rdata` out 3: read data, valid with `usr_ack`.
- `usr_ack` out 1: one-cycle completion pulse.
- `usr_busy` out 1: high whenever state ≠ IDLE.
- `force_test` in 1: request immediate test (level, sampled in IDLE).
- `clear_fault` in 1: clears `fault_flag`.
- `bist_start` out 1: start pulse to BIST engine.
- `bist_marching` in 1: BIST active.
- `bist_success` in 1: BIST result, valid after `bist_marching` falls.
- `bist_address` in 2: BIST RAM-side address.
- `bist_data` in 3: BIST RAM-side data.
- `bist_cs`, `bist_we`, `bist_oe` in 1 each: BIST RAM controls.
- `ram_address` out 2: RAM address pins.
- `ram_data` out 3: RAM data pins.
- `ram_out` in 3: RAM read data.
- `ram_cs`, `ram_we`, `ram_oe` out 1 each: RAM controls.
- `test_count` out 8: completed tests, saturating at 255.
- `fail_count` out 8: failed tests, saturating at 255.
- `fault_flag` out 1: sticky fault indicator.

## Operation
- States: RESYNC, IDLE, USER, USER_ACK, START_TEST, WAIT_MARCH, TESTING, RESULT.
- Reset values:
  - State → RESYNC.
  - All outputs 0, except `ram_data` = 3'bzzz.
  - Period counter 0.
- RESYNC: the BIST engine has no reset. Stay in RESYNC while `bist_marching`=1, with RAM pins muxed to BIST. Otherwise go to IDLE.
- IDLE:
  - Period counter increments each cycle.
  - Test due when counter = `TEST_PERIOD`-1 or `force_test`=1.
  - Test due → START_TEST, which wins over a simultaneous `usr_req`; the request waits.
  - Otherwise `usr_req` → USER.
- USER: drive `ram_cs`=1, `ram_address`=`usr_addr`.
  - Write: `ram_we`=1, `ram_oe`=0, `ram_data`=`usr_wdata`.
  - Read: `ram_oe`=1, `ram_we`=0, `ram_data`=z.
  - Next state USER_ACK.
- USER_ACK:
  - `usr_rdata` ← `ram_out` on reads; unchanged on writes.
  - `usr_ack`=1 for this cycle, then IDLE.
- START_TEST: `bist_start`=1 for 2 cycles, then WAIT_MARCH.
- WAIT_MARCH:
  - `bist_start`=0.
  - `bist_marching`=1 → TESTING.
  - `START_WAIT` cycles elapse first → RESULT with forced fail.
- TESTING:
  - RAM pins are combinationally muxed from `bist_*`.
  - `bist_marching` falls → RESULT.
  - `MARCH_TIMEOUT` reached → RESULT with forced fail.
- RESULT (1 cycle):
  - `test_count`++ (saturating).
  - If `bist_success`=0 or forced fail: `fail_count`++ (saturating) and `fault_flag`=1.
  - Period counter cleared; next state IDLE.
- `clear_fault` clears `fault_flag` in any state. Same cycle as a new failure: set wins.
- User accesses are never granted from START_TEST through RESULT. The transparent march complements RAM contents mid-test and restores them only at its end.

## Timing
- User access latency: `usr_req` sampled high in IDLE at edge k → USER during k..k+1 → `usr_ack` high k+1..k+2.
- Back-to-back requests: next USER no earlier than edge k+3.
- RAM pin mux: registered for user accesses; combinational pass-through from `bist_*` in TESTING and RESYNC.
- `usr_busy` is a registered decode of state.
- Asynchronous reset mid-access aborts silently: no ack, RAM controls drop immediately.
- Counters saturate at 255, no wrap; `fault_flag` is unaffected by saturation.

## Structure
- Shared package `bist_pkg`:
  - state enum;
  - `ADDR_W`=2, `WORD_W`=3, `CNT_W`=8;
  - a saturating-increment function.
- One sub-module, `bist_period_timer`: period counter with `due` output, clear and enable inputs.
- FSM, pin mux and result counters live in the top.

## Test plan
- After reset with `bist_marching`=0: write addr 2 data 3'b101, then read addr 2 → `usr_ack` 2 cycles after each req, `usr_rdata`=3'b101.
- Idle 63 cycles (`TEST_PERIOD`=64) with a fault-free RAM → `bist_start` high for 2 cycles, march completes, `test_count`=1, `fail_count`=0, and addr 2 still reads 3'b101.
- RAM bit stuck-at-0 injected, then `force_test` → `fail_count`=1, `fault_flag`=1; `clear_fault` → `fault_flag`=0 while counters are held.
- `usr_req` and test-due in the same IDLE cycle → test runs first, `usr_busy`=1 throughout, then the request is acked 2 cycles after returning to IDLE.
- `bist_marching` tied 0 → forced fail 4 cycles after `bist_start` drops, `fail_count`++.
- `reset_n` pulsed mid-march → RESYNC holds until `bist_marching` falls, no user ack in between, `test_count`=0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and helpers for the RAM BIST scheduler: FSM states, RAM pin bundle,
// datapath widths and a saturating counter increment.
package bist_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned WORD_W = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_RESYNC,
    S_IDLE,
    S_USER,
    S_USER_ACK,
    S_START_TEST,
    S_WAIT_MARCH,
    S_TESTING,
    S_RESULT
  } state_t;

  typedef struct packed {
    logic              cs;
    logic              we;
    logic              oe;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] data;
  } ram_pins_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bist_period_timer.sv
// Idle-cycle counter that flags when the next automatic BIST run is due.
module bist_period_timer #(
  parameter int unsigned PERIOD = 64
) (
  input  logic in_clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic due
);

  localparam int unsigned CW = $clog2(PERIOD) + 1;

  logic [CW-1:0] cnt;

  // Holds at PERIOD-1 once due so a delayed launch never wraps the count.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !due) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign due = (cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/ram_bist_scheduler.sv
// Arbitrates the RAM pins between functional user accesses and a transparent
// BIST engine, launches periodic/forced marches and tallies their results.
module ram_bist_scheduler
  import bist_pkg::*;
#(
  parameter int unsigned TEST_PERIOD   = 64,
  parameter int unsigned MARCH_TIMEOUT = 64,
  parameter int unsigned START_WAIT    = 4
) (
  input  logic              in_clk,
  input  logic              reset_n,
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [WORD_W-1:0] usr_wdata,
  output logic [WORD_W-1:0] usr_rdata,
  output logic              usr_ack,
  output logic              usr_busy,
  input  logic              force_test,
  input  logic              clear_fault,
  output logic              bist_start,
  input  logic              bist_marching,
  input  logic              bist_success,
  input  logic [ADDR_W-1:0] bist_address,
  input  logic [WORD_W-1:0] bist_data,
  input  logic              bist_cs,
  input  logic              bist_we,
  input  logic              bist_oe,
  output logic [ADDR_W-1:0] ram_address,
  output wire logic [WORD_W-1:0] ram_data,
  input  logic [WORD_W-1:0] ram_out,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [CNT_W-1:0]  test_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              fault_flag
);

  localparam int unsigned PH_MAX = (MARCH_TIMEOUT > START_WAIT) ? MARCH_TIMEOUT : START_WAIT;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 2) + 1;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   phase;
  logic              forced_fail;
  logic              due;
  logic              fail_c;
  logic              bist_mode_c;
  logic              data_en_c;
  logic [WORD_W-1:0] data_val_c;
  ram_pins_t         user_pins;

  bist_period_timer #(.PERIOD(TEST_PERIOD)) u_timer (
    .in_clk  (in_clk),
    .reset_n (reset_n),
    .en      (state == S_IDLE),
    .clr     (state == S_RESULT),
    .due     (due)
  );

  // Next-state decode; a due test always beats a pending user request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESYNC:     if (!bist_marching) state_nxt = S_IDLE;
      S_IDLE: begin
        if (due || force_test) state_nxt = S_START_TEST;
        else if (usr_req)      state_nxt = S_USER;
      end
      S_USER:       state_nxt = S_USER_ACK;
      S_USER_ACK:   state_nxt = S_IDLE;
      S_START_TEST: if (phase == PH_W'(1)) state_nxt = S_WAIT_MARCH;
      S_WAIT_MARCH: begin
        if (bist_marching)                         state_nxt = S_TESTING;
        else if (phase == PH_W'(START_WAIT - 1))   state_nxt = S_RESULT;
      end
      S_TESTING: begin
        if (!bist_marching || phase == PH_W'(MARCH_TIMEOUT - 1)) state_nxt = S_RESULT;
      end
      S_RESULT:     state_nxt = S_IDLE;
      default:      state_nxt = S_RESYNC;
    endcase
  end

  assign fail_c = !bist_success || forced_fail;

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_RESYNC;
      phase       <= '0;
      forced_fail <= 1'b0;
      user_pins   <= '0;
      usr_rdata   <= '0;
      usr_ack     <= 1'b0;
      usr_busy    <= 1'b0;
      bist_start  <= 1'b0;
      test_count  <= '0;
      fail_count  <= '0;
      fault_flag  <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= (state_nxt != state) ? '0 : phase + PH_W'(1);
      // Timeout exits: start never seen, or march still running at the limit.
      forced_fail <= (state == S_WAIT_MARCH) || ((state == S_TESTING) && bist_marching);
      usr_busy    <= (state_nxt != S_IDLE);
      usr_ack     <= (state == S_USER);
      bist_start  <= (state_nxt == S_START_TEST);

      user_pins <= '0;
      if (state_nxt == S_USER) begin
        user_pins.cs      <= 1'b1;
        user_pins.we      <= usr_we;
        user_pins.oe      <= !usr_we;
        user_pins.address <= usr_addr;
        user_pins.data    <= usr_wdata;
      end

      if ((state == S_USER) && user_pins.oe) usr_rdata <= ram_out;

      if (state == S_RESULT) begin
        test_count <= sat_inc(test_count);
        if (fail_c) fail_count <= sat_inc(fail_count);
      end

      if ((state == S_RESULT) && fail_c) fault_flag <= 1'b1;
      else if (clear_fault)              fault_flag <= 1'b0;
    end
  end

  // BIST owns the pins combinationally while marching or possibly still marching after reset.
  assign bist_mode_c = (state == S_TESTING) || (state == S_RESYNC);
  assign ram_cs      = bist_mode_c ? bist_cs      : user_pins.cs;
  assign ram_we      = bist_mode_c ? bist_we      : user_pins.we;
  assign ram_oe      = bist_mode_c ? bist_oe      : user_pins.oe;
  assign ram_address = bist_mode_c ? bist_address : user_pins.address;
  assign data_en_c   = bist_mode_c ? bist_we      : user_pins.we;
  assign data_val_c  = bist_mode_c ? bist_data    : user_pins.data;
  assign ram_data    = data_en_c ? data_val_c : {WORD_W{1'bz}};

endmodule

// File: tb/tb_ram_bist_scheduler.sv
// Directed bench for ram_bist_scheduler with a behavioural 4x3 RAM and a small
// transparent march engine driving the bist_* pins.
module tb_ram_bist_scheduler;

  logic       in_clk = 1'b0;
  logic       reset_n;
  logic       usr_req, usr_we, force_test, clear_fault;
  logic [1:0] usr_addr;
  logic [2:0] usr_wdata, usr_rdata;
  logic       usr_ack, usr_busy, bist_start;
  logic       bist_marching, bist_success, bist_cs, bist_we, bist_oe;
  logic [1:0] bist_address;
  logic [2:0] bist_data;
  logic [1:0] ram_address;
  wire  [2:0] ram_data;
  logic [2:0] ram_out;
  logic       ram_cs, ram_we, ram_oe;
  logic [7:0] test_count, fail_count;
  logic       fault_flag;

  logic [2:0] mem [4] = '{3'b011, 3'b110, 3'b000, 3'b001};
  logic [2:0] stuck_mask;

  int n_tests = 0;
  int n_fail  = 0;

  ram_bist_scheduler dut (
    .in_clk(in_clk), .reset_n(reset_n),
    .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .usr_rdata(usr_rdata), .usr_ack(usr_ack), .usr_busy(usr_busy),
    .force_test(force_test), .clear_fault(clear_fault), .bist_start(bist_start),
    .bist_marching(bist_marching), .bist_success(bist_success),
    .bist_address(bist_address), .bist_data(bist_data),
    .bist_cs(bist_cs), .bist_we(bist_we), .bist_oe(bist_oe),
    .ram_address(ram_address), .ram_data(ram_data), .ram_out(ram_out),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .test_count(test_count), .fail_count(fail_count), .fault_flag(fault_flag)
  );

  always #5 in_clk = ~in_clk;

  // RAM model: synchronous write, asynchronous read with optional stuck-at-0 bits.
  always_comb ram_out = mem[ram_address] & ~stuck_mask;
  always @(posedge in_clk) if (ram_cs && ram_we) mem[ram_address] <= ram_data;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for bist_start, then checks it lasts exactly two cycles.
  task automatic expect_start(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    while (bist_start !== 1'b1 && cyc < max_cyc) begin
      @(negedge in_clk);
      cyc++;
    end
    force_test = 1'b0;
    check({tag, " start rise"}, 32'(bist_start), 32'd1);
    @(negedge in_clk);
    check({tag, " start 2nd cycle"}, 32'(bist_start), 32'd1);
    check({tag, " busy in start"}, 32'(usr_busy), 32'd1);
    @(negedge in_clk);
    check({tag, " start drop"}, 32'(bist_start), 32'd0);
  endtask

  // Transparent march: per address read, write complement, verify, restore, verify.
  task automatic run_march(input int reset_at, output logic ok);
    logic [2:0] orig;
    logic       post;
    orig = '0;
    post = 1'b0;
    ok   = 1'b1;
    bist_marching = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int op = 0; op < 5; op++) begin
        @(negedge in_clk);
        if (post) begin
          check("no ack in resync", 32'(usr_ack), 32'd0);
          check("busy in resync", 32'(usr_busy), 32'd1);
        end
        bist_address = 2'(a);
        bist_cs      = 1'b1;
        bist_we      = (op == 1) || (op == 3);
        bist_oe      = !((op == 1) || (op == 3));
        bist_data    = (op == 1) ? ~orig : orig;
        if (a * 5 + op == reset_at) begin
          reset_n = 1'b0;
          #1;
          reset_n = 1'b1;
          usr_req = 1'b1;
          post    = 1'b1;
        end
        #1;
        if (op == 0) orig = ram_out;
        else if (op == 2 && ram_out !== ~orig) ok = 1'b0;
        else if (op == 4 && ram_out !== orig)  ok = 1'b0;
      end
    end
    @(negedge in_clk);
    bist_cs       = 1'b0;
    bist_we       = 1'b0;
    bist_oe       = 1'b0;
    bist_marching = 1'b0;
    bist_success  = ok;
  endtask

  initial begin
    int   cyc;
    logic ok;
    reset_n = 1'b0;
    usr_req = 1'b0; usr_we = 1'b0; usr_addr = '0; usr_wdata = '0;
    force_test = 1'b0; clear_fault = 1'b0;
    bist_marching = 1'b0; bist_success = 1'b0;
    bist_cs = 1'b0; bist_we = 1'b0; bist_oe = 1'b0;
    bist_address = '0; bist_data = '0;
    stuck_mask = '0;

    repeat (2) @(negedge in_clk);
    check("reset usr_ack", 32'(usr_ack), 32'd0);
    check("reset usr_busy", 32'(usr_busy), 32'd0);
    check("reset bist_start", 32'(bist_start), 32'd0);
    check("reset test_count", 32'(test_count), 32'd0);
    check("reset fail_count", 32'(fail_count), 32'd0);
    check("reset fault_flag", 32'(fault_flag), 32'd0);
    check("reset usr_rdata", 32'(usr_rdata), 32'd0);
    check("reset ram_cs", 32'(ram_cs), 32'd0);
    reset_n = 1'b1;
    @(negedge in_clk);
    check("resync exit busy", 32'(usr_busy), 32'd0);

    // User write then back-to-back read of address 2.
    usr_req = 1'b1; usr_we = 1'b1; usr_addr = 2'd2; usr_wdata = 3'b101;
    @(negedge in_clk);
    check("wr ram_cs", 32'(ram_cs), 32'd1);
    check("wr ram_we", 32'(ram_we), 32'd1);
    check("wr ram_address", 32'(ram_address), 32'd2);
    check("wr ram_data", 32'(ram_data), 32'h5);
    check("wr ack early", 32'(usr_ack), 32'd0);
    check("wr busy", 32'(usr_busy), 32'd1);
    @(negedge in_clk);
    check("wr ack", 32'(usr_ack), 32'd1);
    usr_req = 1'b0;
    @(negedge in_clk);
    check("wr ack pulse", 32'(usr_ack), 32'd0);
    usr_req = 1'b1; usr_we = 1'b0;
    @(negedge in_clk);
    check("rd ram_oe", 32'(ram_oe), 32'd1);
    check("rd ram_we", 32'(ram_we), 32'd0);
    @(negedge in_clk);
    check("rd ack", 32'(usr_ack), 32'd1);
    check("rd data", 32'(usr_rdata), 32'h5);
    usr_req = 1'b0;

    // Automatic periodic test on a fault-free RAM.
    expect_start("period1", 100, cyc);
    run_march(-1, ok);
    check("march1 ok", 32'(ok), 32'd1);
    @(negedge in_clk);
    check("result count pending", 32'(test_count), 32'd0);
    @(negedge in_clk);
    check("march1 test_count", 32'(test_count), 32'd1);
    check("march1 fail_count", 32'(fail_count), 32'd0);
    check("march1 fault_flag", 32'(fault_flag), 32'd0);
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 2'd2;
    repeat (2) @(negedge in_clk);
    check("post-march rd ack", 32'(usr_ack), 32'd1);
    check("post-march rd data", 32'(usr_rdata), 32'h5);
    usr_req = 1'b0;
    @(negedge in_clk);

    // Forced test with a stuck-at-0 bit.
    stuck_mask = 3'b001;
    force_test = 1'b1;
    expect_start("stuck", 10, cyc);
    check("force latency", 32'(cyc), 32'd1);
    run_march(-1, ok);
    stuck_mask = '0;
    check("stuck march detects", 32'(ok), 32'd0);
    repeat (2) @(negedge in_clk);
    check("stuck fail_count", 32'(fail_count), 32'd1);
    check("stuck fault_flag", 32'(fault_flag), 32'd1);
    check("stuck test_count", 32'(test_count), 32'd2);
    clear_fault = 1'b1;
    @(negedge in_clk);
    clear_fault = 1'b0;
    check("clear fault_flag", 32'(fault_flag), 32'd0);
    check("clear holds fail_count", 32'(fail_count), 32'd1);
    check("clear holds test_count", 32'(test_count), 32'd2);

    // Next automatic test exactly 64 idle cycles after RESULT; engine never responds.
    expect_start("timeout", 100, cyc);
    check("period length", 32'(cyc), 32'd63);
    repeat (4) @(negedge in_clk);
    check("timeout not yet counted", 32'(fail_count), 32'd1);
    check("timeout busy", 32'(usr_busy), 32'd1);
    @(negedge in_clk);
    check("timeout fail_count", 32'(fail_count), 32'd2);
    check("timeout test_count", 32'(test_count), 32'd3);
    check("timeout fault_flag", 32'(fault_flag), 32'd1);

    // Test due and user request in the same IDLE cycle: test first.
    force_test = 1'b1;
    usr_req = 1'b1; usr_we = 1'b1; usr_addr = 2'd1; usr_wdata = 3'b010;
    expect_start("collide", 10, cyc);
    check("collide latency", 32'(cyc), 32'd1);
    check("collide no ack", 32'(usr_ack), 32'd0);
    run_march(-1, ok);
    check("collide march ok", 32'(ok), 32'd1);
    check("collide busy testing", 32'(usr_busy), 32'd1);
    @(negedge in_clk);
    check("collide busy result", 32'(usr_busy), 32'd1);
    check("collide ack result", 32'(usr_ack), 32'd0);
    @(negedge in_clk);
    check("collide idle busy", 32'(usr_busy), 32'd0);
    check("collide test_count", 32'(test_count), 32'd4);
    @(negedge in_clk);
    check("collide user busy", 32'(usr_busy), 32'd1);
    check("collide user addr", 32'(ram_address), 32'd1);
    check("collide user ack early", 32'(usr_ack), 32'd0);
    @(negedge in_clk);
    check("collide ack", 32'(usr_ack), 32'd1);
    usr_req = 1'b0;
    @(negedge in_clk);
    usr_req = 1'b1; usr_we = 1'b0;
    repeat (2) @(negedge in_clk);
    check("collide rd ack", 32'(usr_ack), 32'd1);
    check("collide rd data", 32'(usr_rdata), 32'h2);
    usr_req = 1'b0;
    @(negedge in_clk);

    // Reset pulsed mid-march: RESYNC waits out the march, no ack until IDLE.
    force_test = 1'b1;
    usr_we = 1'b1; usr_addr = 2'd3; usr_wdata = 3'b110;
    expect_start("reset", 10, cyc);
    run_march(7, ok);
    check("reset march ok", 32'(ok), 32'd1);
    @(negedge in_clk);
    check("resync idle busy", 32'(usr_busy), 32'd0);
    check("resync idle ack", 32'(usr_ack), 32'd0);
    check("resync test_count", 32'(test_count), 32'd0);
    check("resync fail_count", 32'(fail_count), 32'd0);
    check("resync fault_flag", 32'(fault_flag), 32'd0);
    @(negedge in_clk);
    check("resync user busy", 32'(usr_busy), 32'd1);
    @(negedge in_clk);
    check("resync user ack", 32'(usr_ack), 32'd1);
    usr_req = 1'b0;
    @(negedge in_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
